// File: rtl/reduce_fifo_pkg.sv
// Shared types and register-map addresses for the reduce FIFO engine.
package reduce_fifo_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    // Write map
    localparam int unsigned A_CFG      = 8;
    // Read map
    localparam int unsigned A_OUT_RDY  = 8;
    localparam int unsigned A_OUT_DATA = 9;
    localparam int unsigned A_CFG_RD   = 10;
    localparam int unsigned A_OUT_CNT  = 11;
    localparam int unsigned A_ERR      = 12;

endpackage

// File: rtl/reduce_fifo_engine_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is the combinational front entry.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr_q[IDX_W-1:0]] <= push_data;
        end
    end

    assign head  = mem[rptr_q[IDX_W-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign count = wptr_q - rptr_q;

endmodule

// File: rtl/reduce_fifo_engine.sv
// NUM_IN input FIFOs reduced element-wise (OR/AND/XOR/ADD) into an output FIFO,
// accessed through an address-mapped write port and a registered read port.
module reduce_fifo_engine
    import reduce_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                          write_rdy_q;
    logic                          read_rdy_q;
    op_e                           cfg_q, cfg_d;
    logic                          overflow_q, overflow_d;
    logic                          underflow_q, underflow_d;
    logic [DATA_W-1:0]             read_data_q, read_data_d;

    logic                          wr_go, rd_go;
    logic                          ovf_set, unf_set, err_clr;
    logic [DATA_W-1:0]             rd_val;

    logic [NUM_IN-1:0]             in_push;
    logic [NUM_IN-1:0]             in_full;
    logic [NUM_IN-1:0]             in_empty;
    logic [NUM_IN-1:0][DATA_W-1:0] in_head;
    logic [CNT_W-1:0]              unused_in_count [NUM_IN];

    logic                          fire;
    logic [DATA_W-1:0]             fire_result;
    logic                          out_pop;
    logic                          out_full, out_empty;
    logic [DATA_W-1:0]             out_head;
    logic [CNT_W-1:0]              out_count;

    function automatic logic [DATA_W-1:0] reduce_op(
        input op_e                           op,
        input logic [NUM_IN-1:0][DATA_W-1:0] opnds
    );
        logic [DATA_W-1:0] acc;
        acc = opnds[0];
        for (int i = 1; i < NUM_IN; i++) begin
            case (op)
                OP_OR:   acc = acc | opnds[i];
                OP_AND:  acc = acc & opnds[i];
                OP_XOR:  acc = acc ^ opnds[i];
                OP_ADD:  acc = acc + opnds[i];
                default: acc = acc;
            endcase
        end
        return acc;
    endfunction

    assign wr_go = write_en & write_rdy_q;
    assign rd_go = read_en & read_rdy_q;

    // A pop of the output this cycle frees the slot the fire will fill.
    assign out_pop     = rd_go && (read_address == ADDR_W'(A_OUT_DATA)) && !out_empty;
    assign fire        = (&(~in_empty)) && (!out_full || out_pop);
    assign fire_result = reduce_op(cfg_q, in_head);

    always_comb begin
        in_push = '0;
        ovf_set = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_go && (write_address == ADDR_W'(i))) begin
                if (!in_full[i] || fire) begin
                    in_push[i] = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in_fifo
        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_in_fifo (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .push      (in_push[g]),
            .push_data (write_data),
            .pop       (fire),
            .head      (in_head[g]),
            .full      (in_full[g]),
            .empty     (in_empty[g]),
            .count     (unused_in_count[g])
        );
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_out_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (fire),
        .push_data (fire_result),
        .pop       (out_pop),
        .head      (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (read_address == ADDR_W'(i)) begin
                rd_val[0] = ~in_full[i];
            end
        end
        case (read_address)
            ADDR_W'(A_OUT_RDY):  rd_val[0]   = ~out_empty;
            ADDR_W'(A_OUT_DATA): rd_val      = out_empty ? '0 : out_head;
            ADDR_W'(A_CFG_RD):   rd_val[1:0] = cfg_q;
            ADDR_W'(A_OUT_CNT):  rd_val      = DATA_W'(out_count);
            ADDR_W'(A_ERR):      rd_val[1:0] = {underflow_q, overflow_q};
            default:             ;
        endcase
    end

    // Underflow does not look at a same-cycle fire: the pushed result is not yet readable.
    assign unf_set = rd_go && (read_address == ADDR_W'(A_OUT_DATA)) && out_empty;
    assign err_clr = rd_go && (read_address == ADDR_W'(A_ERR));

    always_comb begin
        cfg_d       = cfg_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        read_data_d = read_data_q;
        if (wr_go && (write_address == ADDR_W'(A_CFG))) begin
            cfg_d = op_e'(write_data[1:0]);
        end
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
        if (unf_set) begin
            underflow_d = 1'b1;
        end
        if (rd_go) begin
            read_data_d = rd_val;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            write_rdy_q <= 1'b0;
            read_rdy_q  <= 1'b0;
            cfg_q       <= OP_OR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            read_data_q <= '0;
        end else begin
            write_rdy_q <= 1'b1;
            read_rdy_q  <= 1'b1;
            cfg_q       <= cfg_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            read_data_q <= read_data_d;
        end
    end

    assign write_rdy = write_rdy_q;
    assign read_rdy  = read_rdy_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_reduce_fifo_engine.sv
// Scoreboard bench: a queue-level reference model predicts every read response.
module tb_reduce_fifo_engine;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_IN = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 4;

    logic              CLK;
    logic              RST_N;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address;
    logic              read_en;
    logic [DATA_W-1:0] read_data;
    logic              read_rdy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_in [NUM_IN][$];
    logic [7:0] m_out[$];
    logic [1:0] m_cfg;
    logic       m_ovf, m_unf;
    logic [7:0] m_hold;
    logic [7:0] exp_q[$];
    logic [3:0] exp_addr[$];
    bit         live;
    bit         mon_issued;

    reduce_fifo_engine #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_IN; i++) m_in[i].delete();
        m_out.delete();
        exp_q.delete();
        exp_addr.delete();
        m_cfg  = 2'b00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_hold = 8'h00;
    endtask

    // One clock edge of the register-map behaviour, expressed on queues.
    task automatic model_step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic re, input logic [3:0] ra);
        bit         fire, out_pop, ovf_set, unf_set;
        logic [7:0] rv;
        int         acc;
        ovf_set = 0;
        unf_set = 0;
        out_pop = re && (ra == 4'd9) && (m_out.size() > 0);
        fire = 1;
        for (int i = 0; i < NUM_IN; i++) if (m_in[i].size() == 0) fire = 0;
        if (!(m_out.size() < DEPTH || out_pop)) fire = 0;

        if (re) begin
            rv = 8'h00;
            if (ra < NUM_IN) rv = (m_in[ra].size() < DEPTH) ? 8'd1 : 8'd0;
            else if (ra == 4'd8) rv = (m_out.size() != 0) ? 8'd1 : 8'd0;
            else if (ra == 4'd9) begin
                if (m_out.size() == 0) unf_set = 1;
                else rv = m_out.pop_front();
            end
            else if (ra == 4'd10) rv = {6'd0, m_cfg};
            else if (ra == 4'd11) rv = 8'(m_out.size());
            else if (ra == 4'd12) rv = {6'd0, m_unf, m_ovf};
            exp_q.push_back(rv);
            exp_addr.push_back(ra);
            m_hold = rv;
        end

        if (fire) begin
            acc = (m_cfg == 2'b01) ? 255 : 0;
            for (int i = 0; i < NUM_IN; i++) begin
                case (m_cfg)
                    2'b00: acc = acc | int'(m_in[i][0]);
                    2'b01: acc = acc & int'(m_in[i][0]);
                    2'b10: acc = acc ^ int'(m_in[i][0]);
                    default: acc = acc + int'(m_in[i][0]);
                endcase
                void'(m_in[i].pop_front());
            end
            m_out.push_back(8'(acc % 256));
        end

        if (we) begin
            if (wa < NUM_IN) begin
                if (m_in[wa].size() < DEPTH) m_in[wa].push_back(wd);
                else ovf_set = 1;
            end else if (wa == 4'd8) begin
                m_cfg = wd[1:0];
            end
        end

        if (re && ra == 4'd12) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (ovf_set) m_ovf = 1;
        if (unf_set) m_unf = 1;
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic re, input logic [3:0] ra);
        @(negedge CLK);
        write_en      = we;
        write_address = wa;
        write_data    = wd;
        read_en       = re;
        read_address  = ra;
        @(posedge CLK);
        if (live) model_step(we, wa, wd, re, ra);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        drive(1'b1, a, d, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        drive(1'b0, 4'd0, 8'd0, 1'b1, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    // Monitor: every live cycle, compare the registered read port against the model.
    always @(posedge CLK) begin
        mon_issued = live && read_en && RST_N;
        #1;
        if (live && RST_N) begin
            if (mon_issued) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_has_entry", 8'd0, 8'd1);
                end else begin
                    check($sformatf("read_addr_%0d", exp_addr.pop_front()), read_data,
                          exp_q.pop_front());
                end
            end else begin
                check("read_data_hold", read_data, m_hold);
            end
        end
    end

    initial begin
        live          = 0;
        RST_N         = 1'b0;
        write_en      = 1'b0;
        write_address = '0;
        write_data    = '0;
        read_en       = 1'b0;
        read_address  = '0;
        model_reset();

        #12;
        check("reset_write_rdy", {7'd0, write_rdy}, 8'd0);
        check("reset_read_rdy", {7'd0, read_rdy}, 8'd0);
        check("reset_read_data", read_data, 8'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(2);
        @(negedge CLK);
        check("post_reset_write_rdy", {7'd0, write_rdy}, 8'd1);
        check("post_reset_read_rdy", {7'd0, read_rdy}, 8'd1);
        check("post_reset_read_data", read_data, 8'd0);
        live = 1;
        rd(4'd8);
        rd(4'd10);

        // OR mode
        wr(4'd0, 8'h0F);
        wr(4'd1, 8'hF0);
        idle(1);
        rd(4'd8);
        rd(4'd9);
        rd(4'd8);

        // ADD wrap, then XOR
        wr(4'd8, 8'h03);
        wr(4'd0, 8'hC0);
        wr(4'd1, 8'h50);
        idle(1);
        rd(4'd9);
        wr(4'd8, 8'h02);
        wr(4'd0, 8'hAA);
        wr(4'd1, 8'hFF);
        idle(1);
        rd(4'd9);
        rd(4'd10);

        // Overflow on input 0
        for (int i = 0; i < 4; i++) wr(4'd0, 8'(8'h10 + i));
        rd(4'd0);
        wr(4'd0, 8'h99);
        rd(4'd12);
        rd(4'd12);
        for (int i = 0; i < 4; i++) wr(4'd1, 8'(8'h20 + i));
        idle(1);
        for (int i = 0; i < 4; i++) rd(4'd9);

        // Underflow, then back-pressure with 8 items per input
        rd(4'd9);
        rd(4'd12);
        wr(4'd8, 8'h03);
        for (int i = 0; i < 8; i++) begin
            wr(4'd0, 8'(i * 17));
            wr(4'd1, 8'(8'h80 + i));
        end
        idle(1);
        rd(4'd11);
        rd(4'd12);
        for (int i = 0; i < 8; i++) rd(4'd9);
        rd(4'd11);

        // Reset mid-stream with three results queued
        wr(4'd8, 8'h01);
        for (int i = 0; i < 3; i++) begin
            wr(4'd0, 8'(8'hF0 | i));
            wr(4'd1, 8'(8'h3C + i));
        end
        idle(1);
        rd(4'd11);
        idle(1);
        @(negedge CLK);
        live  = 0;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("midreset_read_data", read_data, 8'd0);
        check("midreset_read_rdy", {7'd0, read_rdy}, 8'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(2);
        @(negedge CLK);
        live = 1;
        rd(4'd11);
        rd(4'd10);
        rd(4'd8);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic       we, re;
            logic [3:0] wa, ra;
            int         r;
            r  = int'($urandom_range(0, 7));
            we = 1'($urandom);
            wa = (r < 5) ? 4'(r % NUM_IN) : ((r == 5) ? 4'd8 : 4'($urandom));
            re = 1'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom);
            drive(we, wa, 8'($urandom), re, ra);
        end

        idle(2);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reduce_fifo_engine.md
Name: reduce_fifo_engine

Overview:
- Parametrised successor to the team's single-bit, two-input register-mapped FIFO gate DUT.
- NUM_IN input FIFOs, each DATA_W wide, are reduced element-wise by a run-time selectable operator (OR/AND/XOR/ADD) into an output FIFO.
- Host access is through a write port and a read port, each an address/enable/ready interface.
- Sits behind the test wrappers as the standard DUT for interface-level benches.

Parameters:
- DATA_W, 8, width of each input element and of the result.
- NUM_IN, 2, number of input FIFOs/operands (2..8).
- DEPTH, 4, entries per FIFO (power of two, >=2).
- ADDR_W, 4, width of write_address/read_address.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- write_address  input  ADDR_W  write target.
- write_data  input  DATA_W  write payload.
- write_en  input  1  write strobe, one write per cycle.
- write_rdy  output  1  write accepted when high.
- read_address  input  ADDR_W  read target.
- read_en  input  1  read strobe.
- read_data  output  DATA_W  registered read result.
- read_rdy  output  1  read accepted when high.

Behaviour:
- Reset (RST_N low, asynchronous):
  - write_rdy=0, read_rdy=0, read_data=0.
  - All FIFOs empty; cfg_op=OR (2'b00); err flags=0.
  - write_rdy and read_rdy go to 1 on the first clock edge after RST_N deasserts, then remain 1.
- Write map:
  - Address 0..NUM_IN-1: push write_data into input FIFO i.
  - Address 8: cfg_op <= write_data[1:0] (00 OR, 01 AND, 10 XOR, 11 ADD).
  - Any other address: ignored.
- Read map, each updating read_data on the edge after read_en (1-cycle latency):
  - Address 0..NUM_IN-1: {0, ~full_i}.
  - Address 8: {0, ~out_empty}.
  - Address 9: pop output FIFO, return head.
  - Address 10: {0, cfg_op}.
  - Address 11: output FIFO occupancy.
  - Address 12: {0, underflow, overflow}; reading clears both.
  - Other addresses: read_data=0.
  - When read_en=0, read_data holds its value.
- Compute (fire):
  - Fires in any cycle where all input FIFOs are non-empty and the output FIFO is not full, OR is being popped that cycle.
  - On fire: pop one element from every input FIFO; push op(heads) into the output FIFO on the same edge.
  - Result is visible to read at address 9 from the next cycle.
- Latency: write at edge t, fire at edge t+1, read_en at t+2 yields read_data at t+3.
- Arithmetic: ADD is a sum modulo 2^DATA_W, carry discarded. Reductions cover all NUM_IN operands in index order.
- Op selection: the operator used on a fire is cfg_op as registered before that edge. A same-cycle cfg write affects the next fire only.
- Full input FIFO:
  - A push is accepted if the FIFO is being popped by a fire on the same edge.
  - Otherwise the push is dropped and overflow<=1 (sticky).
- Empty output FIFO: a read at address 9 returns 0 and sets underflow<=1 (sticky).
  - A simultaneous fire does not bypass; the read still underflows.
- Clear vs set: reading address 12 clears both flags; a set on that same edge wins.
- Wrap-around: FIFO pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB compare.
- Mid-operation reset: all in-flight data is discarded; nothing is retained.

Decomposition:
- Package reduce_fifo_pkg:
  - op_e enum (OP_OR, OP_AND, OP_XOR, OP_ADD).
  - Address constants: A_CFG=8, A_OUT_RDY=8, A_OUT_DATA=9, A_CFG_RD=10, A_OUT_CNT=11, A_ERR=12.
- Sub-module sync_fifo (DATA_W, DEPTH; push/pop/full/empty/count):
  - Instantiated NUM_IN+1 times.
  - Reduction is a combinational function in the top.

Test Plan:
- Reset then idle two cycles -> write_rdy=1, read_rdy=1, read_data=0; reading address 8 gives 0; reading address 10 gives 0.
- OR mode (NUM_IN=2, DATA_W=8): write 0x0F to addr 0, then 0xF0 to addr 1 -> addr 8 reads 1; addr 9 reads 0xFF; addr 8 then reads 0.
- ADD wrap: write cfg=3; push 0xC0 and 0x50 -> addr 9 reads 0x10; XOR mode with 0xAA,0xFF -> addr 9 reads 0x55.
- Overflow: push 5 items to addr 0 only (DEPTH=4) -> addr 0 reads 0 after the 4th push; addr 12 reads 1; a second read of addr 12 gives 0.
- Underflow plus back-pressure: read addr 9 when empty -> returns 0, addr 12 reads 2. Fill both inputs with 8 items each without reading output -> addr 11 reads 4; after 4 pops of addr 9, the remaining 4 results drain in order.
- Reset mid-stream: assert RST_N low with 3 results queued -> addr 11 reads 0 and cfg reads 0 after release.
